// File: rtl/union_find_pc_if.sv
// Command/response bundle for the union-find engine.
interface union_find_pc_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] node_a;
  logic [ADDR_WIDTH-1:0] node_b;
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_root;
  logic                  rsp_merged;
  logic                  rsp_err;
  logic [ADDR_WIDTH:0]   num_sets;

  modport master (
    output cmd_valid, cmd_op, node_a, node_b,
    input  cmd_ready, rsp_valid, rsp_root, rsp_merged, rsp_err, num_sets
  );

  modport slave (
    input  cmd_valid, cmd_op, node_a, node_b,
    output cmd_ready, rsp_valid, rsp_root, rsp_merged, rsp_err, num_sets
  );
endinterface

// File: rtl/union_find_pc.sv
// Union-find engine: path-splitting FIND, union-by-rank UNION, sequential CLEAR.
module union_find_pc #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int RANK_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  union_find_pc_if.slave bus
);
  localparam int                    IW   = $clog2(N);
  localparam logic [ADDR_WIDTH:0]   NV   = (ADDR_WIDTH+1)'(N);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N-1);
  localparam logic [1:0] OP_NOP = 2'b00, OP_UNION = 2'b01, OP_FIND = 2'b10, OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FIND_A, S_FIND_B, S_MERGE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] parent [N];
  logic [RANK_WIDTH-1:0] rank   [N];

  logic [ADDR_WIDTH-1:0] cur, ra, nb, idx;
  logic                  is_union, clr_rsp;

  // Array read side: one hop lookahead plus the rank pair for the merge decision.
  logic [ADDR_WIDTH-1:0] p_cur, gp;
  logic [RANK_WIDTH-1:0] rank_a, rank_b;
  logic                  at_root, same, a_under_b, accept, a_bad, b_bad, op_err;

  assign p_cur     = parent[cur[IW-1:0]];
  assign gp        = parent[p_cur[IW-1:0]];
  assign at_root   = (p_cur == cur);
  assign rank_a    = rank[ra[IW-1:0]];
  assign rank_b    = rank[cur[IW-1:0]];
  assign same      = (ra == cur);
  assign a_under_b = (rank_a < rank_b);

  assign accept = bus.cmd_valid && (state == S_IDLE);
  assign a_bad  = ({1'b0, bus.node_a} >= NV);
  assign b_bad  = ({1'b0, bus.node_b} >= NV);
  assign op_err = ((bus.cmd_op == OP_FIND) && a_bad) ||
                  ((bus.cmd_op == OP_UNION) && (a_bad || b_bad));

  // State register; reset lands in CLEAR so the arrays get swept after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) begin
        if (bus.cmd_op == OP_CLEAR)                    state_nxt = S_CLEAR;
        else if (bus.cmd_op != OP_NOP && !op_err)      state_nxt = S_FIND_A;
      end
      S_CLEAR:  if (idx == LAST) state_nxt = S_IDLE;
      S_FIND_A: if (at_root)     state_nxt = is_union ? S_FIND_B : S_IDLE;
      S_FIND_B: if (at_root)     state_nxt = S_MERGE;
      S_MERGE:                   state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Output logic: commands are taken only in IDLE.
  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
  end

  // Control datapath: walk cursor, latched operands, response registers, set count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur            <= '0;
      ra             <= '0;
      nb             <= '0;
      idx            <= '0;
      is_union       <= 1'b0;
      clr_rsp        <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_root   <= '0;
      bus.rsp_merged <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.num_sets   <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          cur      <= bus.node_a;
          nb       <= bus.node_b;
          is_union <= (bus.cmd_op == OP_UNION);
          idx      <= '0;
          if (bus.cmd_op == OP_CLEAR) clr_rsp <= 1'b1;
          if (op_err) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= 1'b1;
            bus.rsp_root   <= '0;
            bus.rsp_merged <= 1'b0;
          end
        end
        S_CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            idx          <= '0;
            clr_rsp      <= 1'b0;
            bus.num_sets <= NV;
            // The post-reset sweep is silent; only a commanded CLEAR responds.
            if (clr_rsp) begin
              bus.rsp_valid  <= 1'b1;
              bus.rsp_root   <= '0;
              bus.rsp_merged <= 1'b0;
              bus.rsp_err    <= 1'b0;
            end
          end
        end
        S_FIND_A: begin
          if (!at_root) cur <= p_cur;
          else if (is_union) begin
            ra  <= cur;
            cur <= nb;
          end else begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_root   <= cur;
            bus.rsp_merged <= 1'b0;
            bus.rsp_err    <= 1'b0;
          end
        end
        S_FIND_B: begin
          if (!at_root) cur <= p_cur;
          else begin
            // Response issues on the MERGE cycle; the link itself is written in MERGE.
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= 1'b0;
            bus.rsp_merged <= !same;
            bus.rsp_root   <= (!same && a_under_b) ? cur : ra;
            if (!same) bus.num_sets <= bus.num_sets - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array writes: sweep init, path splitting during walks, rank-based link in MERGE.
  always_ff @(posedge clk) begin
    unique case (state)
      S_CLEAR: begin
        parent[idx[IW-1:0]] <= idx;
        rank[idx[IW-1:0]]   <= '0;
      end
      S_FIND_A, S_FIND_B: if (!at_root) parent[cur[IW-1:0]] <= gp;
      S_MERGE: if (!same) begin
        if (a_under_b) parent[ra[IW-1:0]] <= cur;
        else begin
          parent[cur[IW-1:0]] <= ra;
          if (rank_a == rank_b && rank_a != {RANK_WIDTH{1'b1}})
            rank[ra[IW-1:0]] <= rank_a + 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_union_find_pc.sv
// Scoreboard bench for union_find_pc (N=16, ADDR_WIDTH=5 so out-of-range operands are expressible).
module tb_union_find_pc;
  localparam int N  = 16;
  localparam int AW = 5;
  localparam logic [1:0] NOP = 2'b00, UNI = 2'b01, FND = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  union_find_pc_if #(.ADDR_WIDTH(AW)) bus();

  union_find_pc #(.N(N), .ADDR_WIDTH(AW), .RANK_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] root;
    logic          merged;
    logic          err;
    int            lat;
    int            sets;
    int            acc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid) begin
      if (q.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("root",     32'(bus.rsp_root),   32'(e.root));
        chk("merged",   32'(bus.rsp_merged), 32'(e.merged));
        chk("err",      32'(bus.rsp_err),    32'(e.err));
        chk("latency",  32'(cyc - e.acc),    32'(e.lat));
        chk("num_sets", 32'(bus.num_sets),   32'(e.sets));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Drive one accepted command from a negedge; returns the accept-cycle stamp.
  task automatic issue(input logic [1:0] op, input int a, input int b, output int acc);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.node_a    = AW'(a);
    bus.node_b    = AW'(b);
    acc = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 32'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic cmd(input logic [1:0] op, input int a, input int b,
                     input int root, input int merged, input int err,
                     input int lat, input int sets);
    exp_t e;
    int   acc;
    issue(op, a, b, acc);
    e.root = AW'(root); e.merged = merged[0]; e.err = err[0];
    e.lat = lat; e.sets = sets; e.acc = acc;
    q.push_back(e);
    wait_drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.cmd_ready) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.node_a    = '0;
    bus.node_b    = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready",    32'(bus.cmd_ready),  0);
    chk("rst_rsp",      32'(bus.rsp_valid),  0);
    chk("rst_root",     32'(bus.rsp_root),   0);
    chk("rst_merged",   32'(bus.rsp_merged), 0);
    chk("rst_err",      32'(bus.rsp_err),    0);
    chk("rst_sets",     32'(bus.num_sets),   0);

    reset_n = 1'b1;
    count_to_ready(n);
    chk("sweep_cycles", 32'(n), 16);
    chk("sweep_sets",   32'(bus.num_sets), 16);

    //  op   a   b  root mrg err lat sets
    cmd(FND,  5,  0,   5,  0,  0,  2, 16);
    cmd(UNI,  1,  2,   1,  1,  0,  3, 15);
    cmd(UNI,  3,  4,   3,  1,  0,  3, 14);
    cmd(UNI,  1,  3,   1,  1,  0,  3, 13);
    cmd(FND,  4,  0,   1,  0,  0,  4, 13);   // 4->3->1, two hops
    cmd(UNI,  2,  1,   1,  0,  0,  4, 13);   // da=1, db=0
    cmd(UNI,  7,  7,   7,  0,  0,  3, 13);   // self-union

    // NOP: no response, stays ready (monitor flags anything spurious)
    wait_ready();
    bus.cmd_valid = 1'b1; bus.cmd_op = NOP;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("nop_ready", 32'(bus.cmd_ready), 1);

    // Build 15->14->12->8 from equal-rank pairs
    cmd(UNI,  8,  9,   8,  1,  0,  3, 12);
    cmd(UNI, 10, 11,  10,  1,  0,  3, 11);
    cmd(UNI,  8, 10,   8,  1,  0,  3, 10);
    cmd(UNI, 12, 13,  12,  1,  0,  3,  9);
    cmd(UNI, 14, 15,  14,  1,  0,  3,  8);
    cmd(UNI, 12, 14,  12,  1,  0,  3,  7);
    cmd(UNI,  8, 12,   8,  1,  0,  3,  6);
    cmd(FND, 15,  0,   8,  0,  0,  5,  6);   // 3 hops
    cmd(FND, 15,  0,   8,  0,  0,  4,  6);   // split path: 2 hops
    cmd(FND, 15,  0,   8,  0,  0,  3,  6);   // 1 hop

    // Out-of-range operands
    cmd(FND, 20,  0,   0,  0,  1,  1,  6);
    cmd(UNI,  3, 17,   0,  0,  1,  1,  6);
    cmd(FND,  4,  0,   1,  0,  0,  3,  6);   // unchanged by the errored ops

    // CLEAR then every element is its own root
    cmd(CLR,  0,  0,   0,  0,  0, 17, 16);
    for (int i = 0; i < N; i++) cmd(FND, i, 0, i, 0, 0, 2, 16);

    // Reset while the UNION sits in FIND_B
    issue(UNI, 1, 2, acc);
    @(posedge clk); #1;                      // now in FIND_B
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_rsp",   32'(bus.rsp_valid), 0);
    chk("abort_ready", 32'(bus.cmd_ready), 0);
    chk("abort_sets",  32'(bus.num_sets),  0);
    @(negedge clk);
    reset_n = 1'b1;
    count_to_ready(n);
    chk("abort_sweep", 32'(n), 16);
    chk("abort_sets2", 32'(bus.num_sets), 16);
    cmd(FND,  2,  0,   2,  0,  0,  2, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
